// File: rtl/vscpu_mmio_mem.sv
// Word-addressed RAM plus MMIO timer (COUNT/CMP/CTRL/STATUS) and an output FIFO for the VSCPU bus.
// Reads are registered with 1-cycle latency, read-before-write; irq/out_valid/out_data come straight from registers.
// FIFO head is always presented; a push into a full FIFO without a same-cycle pop is dropped and flags ovf.
module vscpu_mmio_mem #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 14,
    parameter int                RAM_WORDS  = 1024,
    parameter logic [ADDR_W-1:0] MMIO_BASE  = 14'h3FF0,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] addr_toRAM,
    input  logic [DATA_W-1:0] data_toRAM,
    output logic [DATA_W-1:0] data_fromRAM,
    output logic              irq,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] ram [RAM_WORDS] = '{default: '0};
    logic [DATA_W-1:0] fifoMem [FIFO_DEPTH];

    logic [DATA_W-1:0] count, cmp, rdMux;
    logic [2:0]        ctrl;
    logic              match, ovf;
    logic [PTR_W-1:0]  rdPtr, wrPtr;
    logic [3:0]        occ;

    logic        isRam, isMmio, hit;
    logic [3:0]  regOff;
    logic        wrCount, wrCmp, wrCtrl, wrStatus, wrOutq;
    logic        fifoFull, fifoEmpty, pop, pushOk, pushDrop;
    logic [RAM_AW-1:0] ramIdx;

    always_comb begin
        isRam    = (32'(addr_toRAM) < 32'(RAM_WORDS));
        isMmio   = (addr_toRAM[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4]);
        regOff   = addr_toRAM[3:0];
        ramIdx   = addr_toRAM[RAM_AW-1:0];
        wrCount  = wrEn && isMmio && (regOff == 4'd0);
        wrCmp    = wrEn && isMmio && (regOff == 4'd1);
        wrCtrl   = wrEn && isMmio && (regOff == 4'd2);
        wrStatus = wrEn && isMmio && (regOff == 4'd3);
        wrOutq   = wrEn && isMmio && (regOff == 4'd4);
        hit      = ctrl[0] && (count == cmp);
    end

    always_comb begin
        fifoFull  = (occ == 4'(FIFO_DEPTH));
        fifoEmpty = (occ == 4'd0);
        pop       = !fifoEmpty && out_ready;
        // A pop frees a slot in the same cycle, so a full FIFO can still accept.
        pushOk    = wrOutq && (!fifoFull || pop);
        pushDrop  = wrOutq && fifoFull && !pop;
    end

    always_comb begin
        rdMux = '0;
        if (isRam) begin
            rdMux = ram[ramIdx];
        end else if (isMmio) begin
            case (regOff)
                4'd0:    rdMux = count;
                4'd1:    rdMux = cmp;
                4'd2:    rdMux = DATA_W'(ctrl);
                4'd3:    rdMux = DATA_W'({occ, ovf, fifoEmpty, fifoFull, match});
                default: rdMux = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wrEn && isRam) begin
            ram[ramIdx] <= data_toRAM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_fromRAM <= '0;
        end else begin
            data_fromRAM <= rdMux;
        end
    end

    // CPU writes to COUNT win over the timer; hardware match/ovf sets win over W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            cmp   <= '1;
            ctrl  <= '0;
            match <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (wrCount) begin
                count <= data_toRAM;
            end else if (ctrl[0]) begin
                count <= (hit && ctrl[2]) ? '0 : count + 1'b1;
            end
            if (wrCmp) begin
                cmp <= data_toRAM;
            end
            if (wrCtrl) begin
                ctrl <= data_toRAM[2:0];
            end
            if (hit) begin
                match <= 1'b1;
            end else if (wrStatus && data_toRAM[0]) begin
                match <= 1'b0;
            end
            if (pushDrop) begin
                ovf <= 1'b1;
            end else if (wrStatus && data_toRAM[3]) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            occ   <= '0;
        end else begin
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (pushOk) begin
                wrPtr <= wrPtr + 1'b1;
            end
            case ({pushOk, pop})
                2'b10:   occ <= occ + 4'd1;
                2'b01:   occ <= occ - 4'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && pushOk) begin
            fifoMem[wrPtr] <= data_toRAM;
        end
    end

    always_comb begin
        irq       = match & ctrl[1];
        out_valid = !fifoEmpty;
        out_data  = fifoEmpty ? '0 : fifoMem[rdPtr];
    end

endmodule

// File: tb/tb_vscpu_mmio_mem.sv
// Directed and randomized checks of vscpu_mmio_mem against a queue-based behavioural model.
// Every cycle's outputs are compared with the model; directed steps add fixed expected values.
module tb_vscpu_mmio_mem;

    localparam logic [13:0] A_COUNT  = 14'h3FF0;
    localparam logic [13:0] A_CMP    = 14'h3FF1;
    localparam logic [13:0] A_CTRL   = 14'h3FF2;
    localparam logic [13:0] A_STATUS = 14'h3FF3;
    localparam logic [13:0] A_OUTQ   = 14'h3FF4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrEn;
    logic [13:0] addr;
    logic [31:0] dIn;
    logic [31:0] dataFromRam;
    logic        irq;
    logic        outValid;
    logic [31:0] outData;
    logic        outReady;

    int nRun  = 0;
    int nFail = 0;

    logic [31:0] mRam [1024];
    logic [31:0] mCount, mCmp;
    logic [2:0]  mCtrl;
    logic        mMatch, mOvf;
    logic [31:0] q [$];

    vscpu_mmio_mem dut (
        .clk          (clk),
        .rst          (rst),
        .wrEn         (wrEn),
        .addr_toRAM   (addr),
        .data_toRAM   (dIn),
        .data_fromRAM (dataFromRam),
        .irq          (irq),
        .out_valid    (outValid),
        .out_data     (outData),
        .out_ready    (outReady)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nRun++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mCount = 32'h0;
        mCmp   = 32'hFFFF_FFFF;
        mCtrl  = 3'b000;
        mMatch = 1'b0;
        mOvf   = 1'b0;
        q.delete();
    endtask

    function automatic logic [31:0] mRead(input logic [13:0] a);
        if (a < 14'd1024) return mRam[a];
        if (a[13:4] != 10'h3FF) return 32'h0;
        case (a[3:0])
            4'd0:    return mCount;
            4'd1:    return mCmp;
            4'd2:    return {29'h0, mCtrl};
            4'd3:    return {24'h0, 4'(q.size()), mOvf, q.size() == 0, q.size() == 4, mMatch};
            default: return 32'h0;
        endcase
    endfunction

    // One bus cycle: drive, advance the model by one edge, then compare all outputs.
    task automatic tick(input logic we, input logic [13:0] a, input logic [31:0] d, input logic rdy);
        logic [31:0] expRd;
        logic        isM, hitM, fullM, popM;
        logic [31:0] nCount;
        wrEn = we; addr = a; dIn = d; outReady = rdy;
        expRd = mRead(a);
        isM   = we && (a[13:4] == 10'h3FF);
        hitM  = mCtrl[0] && (mCount == mCmp);
        if (isM && a[3:0] == 4'd0)  nCount = d;
        else if (mCtrl[0])          nCount = (hitM && mCtrl[2]) ? 32'h0 : mCount + 32'd1;
        else                        nCount = mCount;
        fullM = (q.size() == 4);
        popM  = (q.size() > 0) && rdy;
        if (popM) void'(q.pop_front());
        if (isM && a[3:0] == 4'd4) begin
            if (!fullM || popM) q.push_back(d);
            else                mOvf = 1'b1;
        end else if (isM && a[3:0] == 4'd3 && d[3]) begin
            mOvf = 1'b0;
        end
        if (hitM)                             mMatch = 1'b1;
        else if (isM && a[3:0] == 4'd3 && d[0]) mMatch = 1'b0;
        if (isM && a[3:0] == 4'd1) mCmp  = d;
        if (isM && a[3:0] == 4'd2) mCtrl = d[2:0];
        mCount = nCount;
        if (we && a < 14'd1024) mRam[a] = d;
        @(posedge clk);
        #1;
        chk("rdata", dataFromRam, expRd);
        chk("irq", 32'(irq), 32'(mMatch & mCtrl[1]));
        chk("out_valid", 32'(outValid), 32'(q.size() != 0));
        if (q.size() != 0) chk("out_data", outData, q[0]);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mRam[i] = 32'h0;
        modelReset();
        rst = 1'b1; wrEn = 1'b0; addr = '0; dIn = '0; outReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", dataFromRam, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_valid", 32'(outValid), 32'h0);
        chk("rst_odata", outData, 32'h0);
        rst = 1'b0;

        // RAM write/read and unmapped read
        tick(1, 14'd100, 32'h0000_1B20, 0);
        tick(0, 14'd100, 32'h0, 0);
        chk("ram100", dataFromRam, 32'h0000_1B20);
        tick(0, 14'd2000, 32'h0, 0);
        chk("unmapped", dataFromRam, 32'h0);

        // Timer with autoclr
        tick(1, A_CMP, 32'd5, 0);
        tick(1, A_CTRL, 32'd7, 0);
        for (int k = 1; k <= 8; k++) begin
            tick(0, A_COUNT, 32'h0, 0);
            chk("autoclr_cnt", dataFromRam, (k <= 6) ? 32'(k - 1) : 32'(k - 7));
            chk("autoclr_irq", 32'(irq), (k >= 6) ? 32'h1 : 32'h0);
        end
        tick(1, A_STATUS, 32'h1, 0);
        chk("w1c_irq", 32'(irq), 32'h0);
        tick(1, A_CTRL, 32'h0, 0);
        tick(1, A_STATUS, 32'h9, 0);

        // Timer wrap without autoclr
        tick(1, A_COUNT, 32'hFFFF_FFFE, 0);
        tick(1, A_CMP, 32'h0, 0);
        tick(1, A_CTRL, 32'h1, 0);
        tick(0, A_COUNT, 32'h0, 0);
        chk("wrap0", dataFromRam, 32'hFFFF_FFFE);
        tick(0, A_COUNT, 32'h0, 0);
        chk("wrap1", dataFromRam, 32'hFFFF_FFFF);
        tick(0, A_COUNT, 32'h0, 0);
        chk("wrap2", dataFromRam, 32'h0);
        tick(0, A_STATUS, 32'h0, 0);
        chk("wrap_match", dataFromRam & 32'h1, 32'h1);
        chk("wrap_irq", 32'(irq), 32'h0);
        tick(1, A_CTRL, 32'h0, 0);
        tick(1, A_STATUS, 32'h9, 0);

        // W1C racing a new match, then COUNT write while running
        tick(1, A_CMP, 32'd5, 0);
        tick(1, A_COUNT, 32'd3, 0);
        tick(1, A_CTRL, 32'd3, 0);
        tick(0, 14'd0, 32'h0, 0);
        tick(0, 14'd0, 32'h0, 0);
        tick(1, A_STATUS, 32'h1, 0);
        tick(0, A_STATUS, 32'h0, 0);
        chk("race_match", dataFromRam & 32'h1, 32'h1);
        chk("race_irq", 32'(irq), 32'h1);
        tick(1, A_COUNT, 32'h6C, 0);
        tick(0, A_COUNT, 32'h0, 0);
        chk("cnt_load", dataFromRam, 32'h6C);
        tick(1, A_CTRL, 32'h0, 0);
        tick(1, A_STATUS, 32'h9, 0);

        // FIFO overflow and drain
        for (int k = 1; k <= 5; k++) tick(1, A_OUTQ, 32'(k), 0);
        tick(0, A_STATUS, 32'h0, 0);
        chk("status_ovf", dataFromRam, 32'h4A);
        for (int k = 1; k <= 4; k++) begin
            chk("drain", outData, 32'(k));
            tick(0, 14'd0, 32'h0, 1);
        end
        chk("drained_valid", 32'(outValid), 32'h0);
        tick(0, A_STATUS, 32'h0, 1);
        chk("drained_empty", (dataFromRam >> 2) & 32'h1, 32'h1);
        tick(1, A_STATUS, 32'h8, 0);

        // Push into a full FIFO while popping
        for (int k = 10; k <= 13; k++) tick(1, A_OUTQ, 32'(k), 0);
        tick(1, A_OUTQ, 32'd14, 1);
        tick(0, A_STATUS, 32'h0, 0);
        chk("full_pushpop", dataFromRam, 32'h42);
        for (int k = 11; k <= 14; k++) begin
            chk("drain2", outData, 32'(k));
            tick(0, 14'd0, 32'h0, 1);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int          sel;
            logic [13:0] a;
            logic [31:0] d;
            sel = $urandom_range(0, 9);
            if (sel < 4)      a = 14'($urandom_range(0, 31));
            else if (sel < 9) a = 14'h3FF0 | 14'($urandom_range(0, 7));
            else              a = 14'h2000 | 14'($urandom_range(0, 4095));
            d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom;
            tick(1'($urandom_range(0, 1)), a, d, ($urandom_range(0, 2) == 0));
        end

        // Async reset mid-drain
        tick(1, A_CTRL, 32'h0, 0);
        tick(1, A_STATUS, 32'h9, 0);
        repeat (6) tick(0, 14'd0, 32'h0, 1);
        tick(1, A_COUNT, 32'h0, 0);
        tick(1, A_CMP, 32'h0, 0);
        tick(1, A_CTRL, 32'h3, 0);
        tick(0, 14'd0, 32'h0, 0);
        for (int k = 1; k <= 4; k++) tick(1, A_OUTQ, 32'(k + 40), 0);
        tick(0, 14'd0, 32'h0, 1);
        tick(0, 14'd100, 32'h0, 0);
        chk("pre_rst_rdata", dataFromRam, 32'h0000_1B20);
        chk("pre_rst_irq", 32'(irq), 32'h1);
        chk("pre_rst_valid", 32'(outValid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(outValid), 32'h0);
        chk("arst_rdata", dataFromRam, 32'h0);
        chk("arst_irq", 32'(irq), 32'h0);
        modelReset();
        wrEn = 1'b1; addr = 14'd100; dIn = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        wrEn = 1'b0;
        rst  = 1'b0;
        tick(0, 14'd100, 32'h0, 0);
        chk("post_rst_ram", dataFromRam, 32'h0000_1B20);
        tick(0, A_STATUS, 32'h0, 0);
        chk("post_rst_status", dataFromRam, 32'h04);

        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end

endmodule
